// File: rtl/serial_addsub_if.sv
// Request/result bundle for serial_addsub: the requester drives operands and start,
// and the adder/subtractor drives status and result.
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cb;
  logic             ovf;

  // start is taken only while the unit is idle.
  // done pulses for one cycle, and result/cb/ovf are valid with it.
  // There is no backpressure, and a start seen while busy is dropped.
  modport master (
    output start, mode, a, b,
    input  busy, done, result, cb, ovf
  );

  modport slave (
    input  start, mode, a, b,
    output busy, done, result, cb, ovf
  );
endinterface

// File: rtl/serial_addsub.sv
// Multi-cycle adder/subtractor that handles STEP bits per clock, LSB first.
// A registered carry/borrow links one slice to the next.
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic               clk,
  input  logic               rst,
  serial_addsub_if.slave     bus,
  output logic [1:0]         state_o
);
  localparam int N    = WIDTH / STEP;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q;
  logic [WIDTH-1:0] a_q, b_q, result_q;
  logic             mode_q, carry_q, cb_q, ovf_q;
  logic [IDXW-1:0]  idx_q;

  logic [STEP-1:0]  sl_a, sl_b, sl_r;
  logic             carry_d, ovf_d, last_slice;

  assign sl_a       = a_q[int'(idx_q) * STEP +: STEP];
  assign sl_b       = b_q[int'(idx_q) * STEP +: STEP];
  assign last_slice = (idx_q == IDXW'(N - 1));

  // Ripple the carry (add) or borrow (sub) through the STEP bits of this slice.
  always_comb begin
    carry_d = carry_q;
    sl_r    = '0;
    for (int k = 0; k < STEP; k++) begin
      sl_r[k] = sl_a[k] ^ sl_b[k] ^ carry_d;
      if (mode_q)
        carry_d = (~sl_a[k] & sl_b[k]) | (carry_d & ~(sl_a[k] ^ sl_b[k]));
      else
        carry_d = (sl_a[k] & sl_b[k]) | (carry_d & (sl_a[k] ^ sl_b[k]));
    end
  end

  // At the last slice, sl_r[STEP-1] is the result MSB.
  always_comb begin
    if (mode_q)
      ovf_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sl_r[STEP-1] != a_q[WIDTH-1]);
    else
      ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sl_r[STEP-1] != a_q[WIDTH-1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      mode_q   <= 1'b0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      result_q <= '0;
      cb_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start == 1'b1) begin
            state_q <= S_RUN;
            a_q     <= bus.a;
            b_q     <= bus.b;
            mode_q  <= bus.mode;
            carry_q <= 1'b0;
            idx_q   <= '0;
          end
        end
        S_RUN: begin
          result_q[int'(idx_q) * STEP +: STEP] <= sl_r;
          carry_q <= carry_d;
          if (last_slice) begin
            state_q <= S_DONE;
            idx_q   <= '0;
            cb_q    <= carry_d;
            ovf_q   <= ovf_d;
          end else begin
            idx_q   <= idx_q + IDXW'(1);
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy   = (state_q == S_RUN) || (state_q == S_DONE);
  assign bus.done   = (state_q == S_DONE);
  assign bus.result = result_q;
  assign bus.cb     = cb_q;
  assign bus.ovf    = ovf_q;
  assign state_o    = state_q;
endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub with STEP = 1, 4 and 8 all running side by side.
// A golden model fills a scoreboard queue for each instance, holding the done cycle and the result.
module tb_serial_addsub;
  localparam int W  = 8;
  localparam int EW = 32 + W + 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   st;
  logic         mode_r;
  logic [W-1:0] a_r, b_r;
  logic [1:0]   state0, state1, state2;
  int unsigned  cyc = 0;
  int           checks = 0;
  int           errors = 0;
  logic [EW-1:0] exp_q[3][$];

  serial_addsub_if #(.WIDTH(W)) u_if0 ();
  serial_addsub_if #(.WIDTH(W)) u_if1 ();
  serial_addsub_if #(.WIDTH(W)) u_if2 ();

  assign u_if0.start = st[0];
  assign u_if1.start = st[1];
  assign u_if2.start = st[2];
  assign u_if0.mode  = mode_r;
  assign u_if1.mode  = mode_r;
  assign u_if2.mode  = mode_r;
  assign u_if0.a     = a_r;
  assign u_if1.a     = a_r;
  assign u_if2.a     = a_r;
  assign u_if0.b     = b_r;
  assign u_if1.b     = b_r;
  assign u_if2.b     = b_r;

  serial_addsub #(.WIDTH(W), .STEP(1)) u_dut0 (.clk(clk), .rst(rst), .bus(u_if0.slave), .state_o(state0));
  serial_addsub #(.WIDTH(W), .STEP(4)) u_dut1 (.clk(clk), .rst(rst), .bus(u_if1.slave), .state_o(state1));
  serial_addsub #(.WIDTH(W), .STEP(8)) u_dut2 (.clk(clk), .rst(rst), .bus(u_if2.slave), .state_o(state2));

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int n_of(input int g);
    return (g == 0) ? 8 : ((g == 1) ? 2 : 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // golden model: arithmetic on widened values, not the bit-slice recurrence
  task automatic push(input int g, input int unsigned acc, input logic m,
                      input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0]   s;
    logic [W-1:0] r;
    logic         c, o;
    if (m) begin
      r = x - y;
      c = (x < y);
      o = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
    end else begin
      s = {1'b0, x} + {1'b0, y};
      r = s[W-1:0];
      c = s[W];
      o = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    end
    exp_q[g].push_back({32'(acc + n_of(g)), r, c, o});
  endtask

  task automatic mon(input int g, input logic dn, input logic [W-1:0] r, input logic c, input logic o);
    logic [EW-1:0] e;
    if (dn) begin
      if (exp_q[g].size() == 0) begin
        check($sformatf("dut%0d_spurious_done", g), 32'(dn), 32'd0);
      end else begin
        e = exp_q[g].pop_front();
        check($sformatf("dut%0d_done_cycle", g), cyc, e[EW-1 -: 32]);
        check($sformatf("dut%0d_result", g), 32'(r), 32'(e[W+1:2]));
        check($sformatf("dut%0d_cb", g), 32'(c), 32'(e[1]));
        check($sformatf("dut%0d_ovf", g), 32'(o), 32'(e[0]));
      end
    end else if (exp_q[g].size() != 0 && cyc > exp_q[g][0][EW-1 -: 32]) begin
      e = exp_q[g].pop_front();
      check($sformatf("dut%0d_done_timeout", g), cyc, e[EW-1 -: 32]);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0, u_if0.done, u_if0.result, u_if0.cb, u_if0.ovf);
      mon(1, u_if1.done, u_if1.result, u_if1.cb, u_if1.ovf);
      mon(2, u_if2.done, u_if2.result, u_if2.cb, u_if2.ovf);
    end
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_state0"}, 32'(state0), 32'd0);
    check({tag, "_state1"}, 32'(state1), 32'd0);
    check({tag, "_state2"}, 32'(state2), 32'd0);
    check({tag, "_busy"}, 32'({u_if0.busy, u_if1.busy, u_if2.busy}), 32'd0);
    check({tag, "_done"}, 32'({u_if0.done, u_if1.done, u_if2.done}), 32'd0);
    check({tag, "_result0"}, 32'(u_if0.result), 32'd0);
    check({tag, "_result1"}, 32'(u_if1.result), 32'd0);
    check({tag, "_result2"}, 32'(u_if2.result), 32'd0);
    check({tag, "_cb"}, 32'({u_if0.cb, u_if1.cb, u_if2.cb}), 32'd0);
    check({tag, "_ovf"}, 32'({u_if0.ovf, u_if1.ovf, u_if2.ovf}), 32'd0);
  endtask

  // Driver: called at a negedge, so the start edge is cyc+1.
  task automatic launch(input logic [2:0] mask, input logic m, input logic [W-1:0] x, input logic [W-1:0] y);
    st = mask; mode_r = m; a_r = x; b_r = y;
    for (int g = 0; g < 3; g++) if (mask[g]) push(g, cyc + 1, m, x, y);
    @(negedge clk);
    st = 3'b000;
    check("busy_after_start", 32'({u_if0.busy, u_if1.busy, u_if2.busy}), 32'(mask));
    a_r = W'($urandom_range(0, 255)); b_r = W'($urandom_range(0, 255)); mode_r = ~m;
  endtask

  task automatic do_op(input logic m, input logic [W-1:0] x, input logic [W-1:0] y);
    launch(3'b111, m, x, y);
    repeat (9) @(negedge clk);
  endtask

  logic [W:0] vec [7] = '{ {1'b0, 8'h05}, {1'b0, 8'hFF}, {1'b0, 8'h7F}, {1'b1, 8'h03},
                           {1'b1, 8'h80}, {1'b1, 8'h00}, {1'b0, 8'h80} };
  logic [W-1:0] vb [7] = '{ 8'h03, 8'h01, 8'h01, 8'h05, 8'h01, 8'h00, 8'h80 };

  initial begin
    rst = 1'b1; st = 3'b000; mode_r = 1'b0; a_r = '0; b_r = '0;
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) do_op(vec[i][W], vec[i][W-1:0], vb[i]);

    // a second start and an X on start while busy must both be ignored
    launch(3'b111, 1'b0, 8'h12, 8'h34);
    @(negedge clk);
    st = 3'b011; mode_r = 1'b1; a_r = 8'hAA; b_r = 8'h55;
    @(negedge clk);
    st = 3'b000;
    @(negedge clk);
    st[0] = 1'bx;
    @(negedge clk);
    st = 3'b000;
    repeat (5) @(negedge clk);

    // asynchronous reset in RUN cycle 4 of the STEP=1 unit
    launch(3'b111, 1'b1, 8'h80, 8'h01);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_state("midop_reset");
    exp_q[0].delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_op(1'b0, 8'h7F, 8'h01);
    do_op(1'b1, 8'h03, 8'h05);

    // start held high: each unit must accept every N+2 cycles
    for (int i = 0; i < 10000; i++) begin
      st = 3'b111;
      mode_r = 1'($urandom_range(0, 1));
      a_r = W'($urandom_range(0, 255));
      b_r = W'($urandom_range(0, 255));
      for (int g = 0; g < 3; g++)
        if (i % (n_of(g) + 2) == 0) push(g, cyc + 1, mode_r, a_r, b_r);
      @(negedge clk);
    end
    st = 3'b000;
    repeat (14) @(negedge clk);

    check("drain_q0", 32'(exp_q[0].size()), 32'd0);
    check("drain_q1", 32'(exp_q[1].size()), 32'd0);
    check("drain_q2", 32'(exp_q[2].size()), 32'd0);
    check("idle_busy", 32'({u_if0.busy, u_if1.busy, u_if2.busy}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
